// File: rtl/mem_arb_pkg.sv
// Shared definitions for the I/D memory arbiter: FSM states, port IDs,
// default wait-cycle count and wait-counter width.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int unsigned DEFAULT_WAIT_CYCLES = 1;
    localparam int unsigned CNT_W               = 4;

endpackage

// File: rtl/mem_arb_picker.sv
// Two-way grant for the memory arbiter. MEM_ARBITER_RR_EN selects round-robin
// with a registered last-grant pointer; otherwise fixed priority with D winning.
module mem_arb_picker
    import mem_arb_pkg::*;
(
`ifdef MEM_ARBITER_RR_EN
    input  logic clk,
    input  logic rst,
    input  logic hs,
`endif
    input  logic en,
    input  logic i_valid,
    input  logic d_valid,
    output logic grant_i,
    output logic grant_d
);

`ifdef MEM_ARBITER_RR_EN
    logic last_q;

    // Pointer starts at D so the first tie after reset goes to I.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= PORT_D;
        end else if (hs) begin
            last_q <= grant_d ? PORT_D : PORT_I;
        end
    end

    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (en) begin
            if (i_valid && d_valid) begin
                if (last_q == PORT_D) begin
                    grant_i = 1'b1;
                end else begin
                    grant_d = 1'b1;
                end
            end else begin
                grant_i = i_valid;
                grant_d = d_valid;
            end
        end
    end
`else
    always_comb begin
        grant_d = en & d_valid;
        grant_i = en & i_valid & ~d_valid;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between the fetch (I) and load/store (D) requesters,
// one timed access per grant. Arbitration policy set by MEM_ARBITER_RR_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_ADDR_WIDTH = 8,
    parameter int unsigned WAIT_CYCLES    = DEFAULT_WAIT_CYCLES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_req_valid,
    output logic                      i_req_ready,
    input  logic [31:0]               i_addr,
    output logic                      i_resp_valid,
    output logic [31:0]               i_rdata,
    input  logic                      d_req_valid,
    output logic                      d_req_ready,
    input  logic                      d_wen,
    input  logic [31:0]               d_addr,
    input  logic [31:0]               d_wdata,
    output logic                      d_resp_valid,
    output logic [31:0]               d_rdata,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic                      mem_rden,
    output logic                      mem_wren,
    output logic [31:0]               mem_wdata,
    input  logic [31:0]               mem_rdata
);

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q;
    logic                      port_q;
    logic                      wen_q;
    logic [MEM_ADDR_WIDTH-1:0] addr_q;
    logic [31:0]               wdata_q;
    logic [31:0]               i_rdata_q, d_rdata_q;
    logic                      grant_i, grant_d, hs, idle;

    // Byte-offset and wrap-around bits are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[31:MEM_ADDR_WIDTH+2], i_addr[1:0],
                                d_addr[31:MEM_ADDR_WIDTH+2], d_addr[1:0]};

    assign idle = (state_q == IDLE);

    mem_arb_picker u_picker (
`ifdef MEM_ARBITER_RR_EN
        .clk     (clk),
        .rst     (rst),
        .hs      (hs),
`endif
        .en      (idle),
        .i_valid (i_req_valid),
        .d_valid (d_req_valid),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

    assign i_req_ready  = grant_i;
    assign d_req_ready  = grant_d;
    assign hs           = (i_req_valid & grant_i) | (d_req_valid & grant_d);
    assign i_resp_valid = (state_q == RESP) && (port_q == PORT_I);
    assign d_resp_valid = (state_q == RESP) && (port_q == PORT_D);
    assign i_rdata      = i_rdata_q;
    assign d_rdata      = d_rdata_q;

    // Memory strobes decode from registered state, so reset kills mem_wren at once.
    always_comb begin
        state_d   = state_q;
        mem_rden  = 1'b0;
        mem_wren  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            IDLE: begin
                if (hs) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                mem_rden  = ~wen_q;
                mem_wren  = wen_q && (cnt_q == '0);
                if (cnt_q == '0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            port_q    <= PORT_I;
            wen_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (hs) begin
                        port_q  <= grant_d ? PORT_D : PORT_I;
                        addr_q  <= grant_d ? d_addr[MEM_ADDR_WIDTH+1:2]
                                           : i_addr[MEM_ADDR_WIDTH+1:2];
                        wen_q   <= grant_d & d_wen;
                        wdata_q <= grant_d ? d_wdata : '0;
                        cnt_q   <= CNT_W'(WAIT_CYCLES - 1);
                    end
                end
                ACCESS: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (port_q == PORT_D) begin
                        d_rdata_q <= wen_q ? '0 : mem_rdata;
                    end else begin
                        i_rdata_q <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (WAIT_CYCLES 1 and 3), each with its own
// ideal memory, checked against a transaction-level model of the arbiter.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req_valid  [2];
    logic        i_req_ready  [2];
    logic [31:0] i_addr       [2];
    logic        i_resp_valid [2];
    logic [31:0] i_rdata      [2];
    logic        d_req_valid  [2];
    logic        d_req_ready  [2];
    logic        d_wen        [2];
    logic [31:0] d_addr       [2];
    logic [31:0] d_wdata      [2];
    logic        d_resp_valid [2];
    logic [31:0] d_rdata      [2];
    logic [7:0]  mem_addr     [2];
    logic        mem_rden     [2];
    logic        mem_wren     [2];
    logic [31:0] mem_wdata    [2];
    logic [31:0] mem_rdata    [2];

    logic [31:0] mem    [2][256];
    logic [31:0] shadow [2][256];
    logic        fill, poke_en, poke_k;
    logic [7:0]  poke_a;
    logic [31:0] poke_d;

    mem_arbiter #(.MEM_ADDR_WIDTH(8), .WAIT_CYCLES(1)) dut0 (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid[0]), .i_req_ready(i_req_ready[0]), .i_addr(i_addr[0]),
        .i_resp_valid(i_resp_valid[0]), .i_rdata(i_rdata[0]),
        .d_req_valid(d_req_valid[0]), .d_req_ready(d_req_ready[0]), .d_wen(d_wen[0]),
        .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
        .d_resp_valid(d_resp_valid[0]), .d_rdata(d_rdata[0]),
        .mem_addr(mem_addr[0]), .mem_rden(mem_rden[0]), .mem_wren(mem_wren[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
    );

    mem_arbiter #(.MEM_ADDR_WIDTH(8), .WAIT_CYCLES(3)) dut1 (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid[1]), .i_req_ready(i_req_ready[1]), .i_addr(i_addr[1]),
        .i_resp_valid(i_resp_valid[1]), .i_rdata(i_rdata[1]),
        .d_req_valid(d_req_valid[1]), .d_req_ready(d_req_ready[1]), .d_wen(d_wen[1]),
        .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
        .d_resp_valid(d_resp_valid[1]), .d_rdata(d_rdata[1]),
        .mem_addr(mem_addr[1]), .mem_rden(mem_rden[1]), .mem_wren(mem_wren[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] hashv(input int k, input int a);
        return (32'h9E3779B9 * 32'(a + 1)) ^ (32'h01010101 * 32'(k + 1));
    endfunction

    // Ideal memory: asynchronous read, write committed at the rising edge.
    assign mem_rdata[0] = mem[0][mem_addr[0]];
    assign mem_rdata[1] = mem[1][mem_addr[1]];

    always @(posedge clk) begin
        if (fill) begin
            for (int k = 0; k < 2; k++)
                for (int a = 0; a < 256; a++)
                    mem[k][a] <= hashv(k, a);
        end else if (poke_en) begin
            mem[poke_k][poke_a] <= poke_d;
        end else begin
            if (mem_wren[0]) mem[0][mem_addr[0]] <= mem_wdata[0];
            if (mem_wren[1]) mem[1][mem_addr[1]] <= mem_wdata[1];
        end
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string nm, input int k, input logic [127:0] got,
                         input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s dut%0d @%0t: got %0h expected %0h", nm, k, $time, got, exp);
    endtask

    function automatic logic [109:0] outs(input int k);
        return {i_req_ready[k], d_req_ready[k], i_resp_valid[k], d_resp_valid[k],
                mem_rden[k], mem_wren[k], mem_addr[k], mem_wdata[k], i_rdata[k], d_rdata[k]};
    endfunction

    function automatic int wc(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
    } op_t;

    op_t         qi[$];
    op_t         qd[$];
    logic        last_d      [2];
    logic [31:0] exp_irdata  [2];
    logic [31:0] exp_drdata  [2];

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            last_d[k]     = 1'b1;
            exp_irdata[k] = '0;
            exp_drdata[k] = '0;
            i_req_valid[k] = 1'b0;
            d_req_valid[k] = 1'b0;
        end
        qi.delete();
        qd.delete();
    endtask

    task automatic poke(input int k, input int a, input logic [31:0] d);
        poke_en = 1'b1; poke_k = k[0]; poke_a = 8'(a); poke_d = d;
        @(posedge clk); #1;
        poke_en = 1'b0;
        shadow[k][a] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_clear();
        @(posedge clk); @(posedge clk); #1;
        for (int k = 0; k < 2; k++) check("reset_outputs", k, outs(k), '0);
        rst = 1'b0;
    endtask

    // Transaction-level model: requesters present queue heads; each grant costs
    // WAIT_CYCLES access cycles plus one response cycle, memory serialised.
    task automatic engine(input int k, input int n_rand, input int budget);
        int          cyc = 0, injected = 0, hs_cyc = 0, off;
        bit          busy = 0, acc, iv, dv, win_i, win_d;
        logic        hs_port = 1'b0, hs_wen = 1'b0;
        logic [7:0]  hs_a = '0;
        logic [31:0] hs_wd = '0, hs_exp = '0;
        logic [5:0]  ectl;
        logic [109:0] g, e;
        op_t         op;
        forever begin
            if (!busy && qi.size() == 0 && qd.size() == 0 && injected >= n_rand) break;
            if (cyc >= budget) begin
                check("engine_timeout", k, 1, 0);
                qi.delete(); qd.delete();
                break;
            end
            @(posedge clk); #1;
            if (injected < n_rand && $urandom_range(0, 2) == 0) begin
                op.addr = $urandom;
                op.addr[9:2] = 8'($urandom_range(0, 15));
                op.wdata = $urandom;
                if ($urandom_range(0, 1) == 1) begin
                    op.wen = 1'b0;
                    qi.push_back(op);
                end else begin
                    op.wen = 1'($urandom_range(0, 1));
                    qd.push_back(op);
                end
                injected++;
            end
            iv = (qi.size() > 0);
            dv = (qd.size() > 0);
            i_req_valid[k] = iv;
            d_req_valid[k] = dv;
            if (iv) i_addr[k] = qi[0].addr;
            if (dv) begin
                d_addr[k] = qd[0].addr; d_wen[k] = qd[0].wen; d_wdata[k] = qd[0].wdata;
            end
            @(negedge clk);
            acc = 1'b0;
            if (busy) begin
                off = cyc - hs_cyc;
                if (off <= wc(k)) begin
                    acc  = 1'b1;
                    ectl = {4'b0000, ~hs_wen, hs_wen && (off == wc(k))};
                end else begin
                    ectl = {2'b00, hs_port == 1'b0, hs_port == 1'b1, 2'b00};
                    if (hs_port) exp_drdata[k] = hs_exp;
                    else         exp_irdata[k] = hs_exp;
                    busy = 1'b0;
                end
            end else begin
`ifdef MEM_ARBITER_RR_EN
                win_i = iv && (!dv || last_d[k]);
`else
                win_i = iv && !dv;
`endif
                win_d = dv && !win_i;
                ectl  = {win_i, win_d, 4'b0000};
                if (win_i || win_d) begin
                    op = win_d ? qd.pop_front() : qi.pop_front();
                    busy = 1'b1; hs_cyc = cyc; hs_port = win_d;
                    hs_a = op.addr[9:2]; hs_wen = win_d && op.wen; hs_wd = op.wdata;
                    if (hs_wen) begin
                        shadow[k][hs_a] = hs_wd;
                        hs_exp = '0;
                    end else begin
                        hs_exp = shadow[k][hs_a];
                    end
                    last_d[k] = win_d;
                end
            end
            g = {i_req_ready[k], d_req_ready[k], i_resp_valid[k], d_resp_valid[k],
                 mem_rden[k], mem_wren[k], acc ? mem_addr[k] : 8'h00,
                 (acc && hs_wen) ? mem_wdata[k] : 32'h0, i_rdata[k], d_rdata[k]};
            e = {ectl, acc ? hs_a : 8'h00, (acc && hs_wen) ? hs_wd : 32'h0,
                 exp_irdata[k], exp_drdata[k]};
            check("cycle", k, g, e);
            cyc++;
        end
        @(posedge clk); #1;
        i_req_valid[k] = 1'b0;
        d_req_valid[k] = 1'b0;
    endtask

    typedef struct {
        logic iv;
        logic dv;
        logic eir;
        logic edr;
    } rdy_vec_t;

    rdy_vec_t tbl [4];
    op_t      t_op;
    bit       seen;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        fill = 1'b1; poke_en = 1'b0; poke_k = 1'b0; poke_a = '0; poke_d = '0;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            i_addr[k] = '0; d_addr[k] = '0; d_wen[k] = 1'b0; d_wdata[k] = '0;
            for (int a = 0; a < 256; a++) shadow[k][a] = hashv(k, a);
        end
        model_clear();
        @(posedge clk); #1;
        fill = 1'b0;
        do_reset();

        // Ready decode in IDLE, valids withdrawn before the edge so nothing is accepted.
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1};
`ifdef MEM_ARBITER_RR_EN
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0};
`else
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1};
`endif
        for (int v = 0; v < 4; v++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                i_req_valid[k] = tbl[v].iv;
                d_req_valid[k] = tbl[v].dv;
            end
            #2;
            for (int k = 0; k < 2; k++)
                check("ready_table", k, {i_req_ready[k], d_req_ready[k]}, {tbl[v].eir, tbl[v].edr});
            for (int k = 0; k < 2; k++) begin
                i_req_valid[k] = 1'b0;
                d_req_valid[k] = 1'b0;
            end
        end

        // Reset during the write cycle of a store.
        poke(0, 3, 32'h12345678);
        @(posedge clk); #1;
        d_req_valid[0] = 1'b1; d_wen[0] = 1'b1; d_addr[0] = 32'h0000000C; d_wdata[0] = '1;
        @(negedge clk);
        check("rst_store_ready", 0, d_req_ready[0], 1);
        @(posedge clk); #1;
        d_req_valid[0] = 1'b0;
        @(negedge clk);
        check("rst_store_wren", 0, {mem_wren[0], mem_addr[0]}, {1'b1, 8'd3});
        rst = 1'b1;
        #1;
        check("rst_async_outputs", 0, outs(0), '0);
        @(posedge clk); @(posedge clk); #1;
        check("rst_word3_kept", 0, mem[0][3], 32'h12345678);
        rst = 1'b0;
        model_clear();
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (d_resp_valid[0]) seen = 1'b1;
        end
        check("rst_no_resp", 0, seen, 0);

        // Single fetch of word 5.
        poke(0, 5, 32'h0C00000E);
        t_op = '{32'h00000014, 1'b0, 32'h0};
        qi.push_back(t_op);
        engine(0, 0, 50);
        check("fetch_rdata", 0, i_rdata[0], 32'h0C00000E);

        // Store zero to word 3, then load it back.
        t_op = '{32'h0000000C, 1'b1, 32'h00000000};
        qd.push_back(t_op);
        t_op = '{32'h0000000C, 1'b0, 32'hDEADBEEF};
        qd.push_back(t_op);
        engine(0, 0, 50);
        check("store_load_word3", 0, {mem[0][3], d_rdata[0]}, 64'h0);

        // Misaligned address beyond the 1 KB window wraps to word 0.
        poke(1, 0, 32'hA5A50001);
        t_op = '{32'h00000403, 1'b0, 32'h0};
        qd.push_back(t_op);
        engine(1, 0, 50);
        check("wrap_rdata", 1, d_rdata[1], 32'hA5A50001);

        // Both requesters busy from the first cycle.
        do_reset();
        for (int n = 0; n < 4; n++) begin
            t_op = '{32'h00000100 + 32'(4 * n), 1'b0, 32'h0};
            qi.push_back(t_op);
            t_op = '{32'h00000200 + 32'(4 * n), 1'b0, 32'h0};
            qd.push_back(t_op);
        end
        engine(1, 0, 200);

        engine(0, 80, 4000);
        engine(1, 80, 6000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
